// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generator for the EXE stage.
// A shadow pipeline (EX and MEM slots) tracks the destination registers of
// in-flight instructions. The decode instruction's sources are compared
// against these slots. The resulting select codes are registered, so they
// line up with the ID/EX pipeline register outputs.
// Select codes: 0=regfile, 1=MEM result, 2=WB result, 3=MEM result2, 4=WB result2.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_complex,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rs3,
  input  logic [REG_AW-1:0] id_rs4,
  input  logic [REG_AW-1:0] id_st,
  input  logic [REG_AW-1:0] id_st2,
  input  logic [5:0]        id_use,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rd2,
  input  logic              id_we,
  input  logic              id_we2,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        alu_input1_sel,
  output logic [1:0]        alu_input2_sel,
  output logic [1:0]        store_val_sel,
  output logic [2:0]        alu_input1_sel_C,
  output logic [2:0]        alu_input2_sel_C,
  output logic [2:0]        alu_input3_sel_C,
  output logic [2:0]        alu_input4_sel_C,
  output logic [2:0]        store_val_sel_C,
  output logic [2:0]        store_val2_sel,
  output logic [CNT_W-1:0]  stall_count
);

  // Shadow slot for the instruction currently in EX
  logic              ex_valid_q, ex_we_q, ex_we2_q, ex_mr_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rd2_q;
  // Shadow slot for the instruction currently in MEM
  logic              mem_valid_q, mem_we_q, mem_we2_q, mem_mr_q;
  logic [REG_AW-1:0] mem_rd_q, mem_rd2_q;

  logic [17:0]       cplx_sel_q, cplx_sel_d;
  logic [5:0]        simp_sel_q, simp_sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Source index per slot: rs, rt, rs3, rs4, st, st2 (matches id_use bit order)
  logic [REG_AW-1:0] src [6];
  assign src[0] = id_rs;
  assign src[1] = id_rt;
  assign src[2] = id_rs3;
  assign src[3] = id_rs4;
  assign src[4] = id_st;
  assign src[5] = id_st2;

  logic [17:0] cplx_code;   // 3 bits per source
  logic [11:0] simp_code;   // 2 bits per source
  logic [5:0]  lu_hit;      // source needs the EX-slot rd

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_src
      logic       live;
      logic       ex_hit_rd, ex_hit_rd2, mem_hit_rd, mem_hit_rd2;
      logic [2:0] c_code;
      logic [1:0] s_code;

      // Register 0 is hardwired, so it never forwards
      assign live        = id_use[gi] && (src[gi] != '0);
      assign ex_hit_rd   = live && ex_valid_q  && ex_we_q   && (src[gi] == ex_rd_q);
      assign ex_hit_rd2  = live && ex_valid_q  && ex_we2_q  && (src[gi] == ex_rd2_q);
      assign mem_hit_rd  = live && mem_valid_q && mem_we_q  && (src[gi] == mem_rd_q);
      assign mem_hit_rd2 = live && mem_valid_q && mem_we2_q && (src[gi] == mem_rd2_q);

      // Priority select: the youngest producer wins; EX becomes MEM and MEM becomes WB on issue
      always_comb begin
        c_code = 3'd0;
        s_code = 2'd0;
        if (ex_hit_rd)        c_code = 3'd1;
        else if (ex_hit_rd2)  c_code = 3'd3;
        else if (mem_hit_rd)  c_code = 3'd2;
        else if (mem_hit_rd2) c_code = 3'd4;
        if (ex_hit_rd)        s_code = 2'd1;
        else if (mem_hit_rd)  s_code = 2'd2;
      end

      assign cplx_code[gi*3 +: 3] = c_code;
      assign simp_code[gi*2 +: 2] = s_code;
      assign lu_hit[gi]           = live && (src[gi] == ex_rd_q);
    end
  endgenerate

  // A load in EX cannot forward in time; hold decode one cycle. Flush overrides.
  assign stall = id_valid && !flush && ex_valid_q && ex_mr_q && ex_we_q && (|lu_hit);

  // Next values of the select registers and the saturating stall counter
  always_comb begin
    cplx_sel_d = 18'd0;
    simp_sel_d = 6'd0;
    if (!flush && !stall && id_valid) begin
      cplx_sel_d = cplx_code;
      simp_sel_d = {simp_code[9:8], simp_code[3:2], simp_code[1:0]};
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Advance the shadow pipeline and capture the select codes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_we_q     <= 1'b0;
      ex_we2_q    <= 1'b0;
      ex_mr_q     <= 1'b0;
      ex_rd_q     <= '0;
      ex_rd2_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_we2_q   <= 1'b0;
      mem_mr_q    <= 1'b0;
      mem_rd_q    <= '0;
      mem_rd2_q   <= '0;
      cplx_sel_q  <= 18'd0;
      simp_sel_q  <= 6'd0;
      cnt_q       <= '0;
    end else begin
      mem_valid_q <= ex_valid_q;
      mem_we_q    <= ex_we_q;
      mem_we2_q   <= ex_we2_q;
      mem_mr_q    <= ex_mr_q;
      mem_rd_q    <= ex_rd_q;
      mem_rd2_q   <= ex_rd2_q;
      if (flush || stall) begin
        ex_valid_q <= 1'b0;
        ex_we_q    <= 1'b0;
        ex_we2_q   <= 1'b0;
        ex_mr_q    <= 1'b0;
        ex_rd_q    <= '0;
        ex_rd2_q   <= '0;
      end else begin
        ex_valid_q <= id_valid;
        ex_we_q    <= id_we;
        ex_we2_q   <= id_we2;
        ex_mr_q    <= id_mem_read;
        ex_rd_q    <= id_rd;
        ex_rd2_q   <= id_rd2;
      end
      cplx_sel_q <= cplx_sel_d;
      simp_sel_q <= simp_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign alu_input1_sel   = simp_sel_q[1:0];
  assign alu_input2_sel   = simp_sel_q[3:2];
  assign store_val_sel    = simp_sel_q[5:4];
  assign alu_input1_sel_C = cplx_sel_q[2:0];
  assign alu_input2_sel_C = cplx_sel_q[5:3];
  assign alu_input3_sel_C = cplx_sel_q[8:6];
  assign alu_input4_sel_C = cplx_sel_q[11:9];
  assign store_val_sel_C  = cplx_sel_q[14:12];
  assign store_val2_sel   = cplx_sel_q[17:15];
  assign stall_count      = cnt_q;

  // id_complex does not change select generation; the EXE stage picks the set
  logic unused_ok;
  assign unused_ok = id_complex ^ mem_mr_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl: one task per scenario, inline checks.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_complex;
  logic [4:0] id_rs, id_rt, id_rs3, id_rs4, id_st, id_st2, id_rd, id_rd2;
  logic [5:0] id_use;
  logic       id_we, id_we2, id_mem_read, flush;
  logic       stall;
  logic [1:0] alu_input1_sel, alu_input2_sel, store_val_sel;
  logic [2:0] alu_input1_sel_C, alu_input2_sel_C, alu_input3_sel_C, alu_input4_sel_C;
  logic [2:0] store_val_sel_C, store_val2_sel;
  logic [15:0] stall_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_complex(id_complex),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs3(id_rs3), .id_rs4(id_rs4),
    .id_st(id_st), .id_st2(id_st2), .id_use(id_use),
    .id_rd(id_rd), .id_rd2(id_rd2), .id_we(id_we), .id_we2(id_we2),
    .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall),
    .alu_input1_sel(alu_input1_sel), .alu_input2_sel(alu_input2_sel),
    .store_val_sel(store_val_sel),
    .alu_input1_sel_C(alu_input1_sel_C), .alu_input2_sel_C(alu_input2_sel_C),
    .alu_input3_sel_C(alu_input3_sel_C), .alu_input4_sel_C(alu_input4_sel_C),
    .store_val_sel_C(store_val_sel_C), .store_val2_sel(store_val2_sel),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic clear_id();
    id_valid = 0; id_complex = 0;
    id_rs = 0; id_rt = 0; id_rs3 = 0; id_rs4 = 0; id_st = 0; id_st2 = 0;
    id_use = 0; id_rd = 0; id_rd2 = 0; id_we = 0; id_we2 = 0;
    id_mem_read = 0; flush = 0;
  endtask

  // One clock edge; outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two idle cycles empty both shadow slots
  task automatic drain();
    clear_id();
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1;
    clear_id();
    id_valid = 1; id_rs = 5'd5; id_use = 6'b000001; id_rd = 5'd5; id_we = 1;
    step();
    step();
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %0d want 0", stall); end
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL reset_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd0) begin err_cnt++; $display("FAIL reset_sel1C: got %0d want 0", alu_input1_sel_C); end
    vec_cnt++; if (store_val2_sel !== 3'd0) begin err_cnt++; $display("FAIL reset_sv2: got %0d want 0", store_val2_sel); end
    vec_cnt++; if (stall_count !== 16'd0) begin err_cnt++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
    @(negedge clk);
    rst = 0;
    clear_id();
    step();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    drain();
    id_valid = 1; id_rd = 5'd5; id_we = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 5'd5; id_rt = 5'd5; id_rs3 = 5'd5; id_use = 6'b000011;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL b2b_stall: got %0d want 0", stall); end
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd1) begin err_cnt++; $display("FAIL b2b_sel1: got %0d want 1", alu_input1_sel); end
    vec_cnt++; if (alu_input2_sel !== 2'd1) begin err_cnt++; $display("FAIL b2b_sel2: got %0d want 1", alu_input2_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd1) begin err_cnt++; $display("FAIL b2b_sel1C: got %0d want 1", alu_input1_sel_C); end
    vec_cnt++; if (alu_input2_sel_C !== 3'd1) begin err_cnt++; $display("FAIL b2b_sel2C: got %0d want 1", alu_input2_sel_C); end
    // rs3 matches but its use bit is clear
    vec_cnt++; if (alu_input3_sel_C !== 3'd0) begin err_cnt++; $display("FAIL b2b_unused3C: got %0d want 0", alu_input3_sel_C); end
    // store sources
    drain();
    id_valid = 1; id_rd = 5'd6; id_we = 1;
    step();
    clear_id();
    id_valid = 1; id_st = 5'd6; id_st2 = 5'd6; id_use = 6'b110000;
    step();
    vec_cnt++; if (store_val_sel !== 2'd1) begin err_cnt++; $display("FAIL b2b_svs: got %0d want 1", store_val_sel); end
    vec_cnt++; if (store_val_sel_C !== 3'd1) begin err_cnt++; $display("FAIL b2b_svsC: got %0d want 1", store_val_sel_C); end
    vec_cnt++; if (store_val2_sel !== 3'd1) begin err_cnt++; $display("FAIL b2b_sv2: got %0d want 1", store_val2_sel); end
    $display("test_back_to_back done");
  endtask

  task automatic test_distance2();
    drain();
    id_valid = 1; id_rd = 5'd7; id_we = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 5'd1; id_use = 6'b000001; id_rd = 5'd8; id_we = 1;
    step();
    clear_id();
    id_valid = 1; id_complex = 1; id_rs = 5'd2; id_rs3 = 5'd7; id_use = 6'b000101;
    step();
    vec_cnt++; if (alu_input3_sel_C !== 3'd2) begin err_cnt++; $display("FAIL d2_sel3C: got %0d want 2", alu_input3_sel_C); end
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL d2_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd0) begin err_cnt++; $display("FAIL d2_sel1C: got %0d want 0", alu_input1_sel_C); end
    $display("test_distance2 done");
  endtask

  task automatic test_dual_result();
    drain();
    id_valid = 1; id_complex = 1; id_rd = 5'd3; id_rd2 = 5'd4; id_we = 1; id_we2 = 1;
    step();
    clear_id();
    id_valid = 1; id_complex = 1; id_rs = 5'd4; id_rt = 5'd3; id_use = 6'b000011;
    step();
    vec_cnt++; if (alu_input1_sel_C !== 3'd3) begin err_cnt++; $display("FAIL dual_sel1C: got %0d want 3", alu_input1_sel_C); end
    vec_cnt++; if (alu_input2_sel_C !== 3'd1) begin err_cnt++; $display("FAIL dual_sel2C: got %0d want 1", alu_input2_sel_C); end
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL dual_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input2_sel !== 2'd1) begin err_cnt++; $display("FAIL dual_sel2: got %0d want 1", alu_input2_sel); end
    // distance 2
    drain();
    id_valid = 1; id_complex = 1; id_rd = 5'd3; id_rd2 = 5'd4; id_we = 1; id_we2 = 1;
    step();
    clear_id();
    step();
    id_valid = 1; id_complex = 1; id_rs = 5'd4; id_rt = 5'd3; id_use = 6'b000011;
    step();
    vec_cnt++; if (alu_input1_sel_C !== 3'd4) begin err_cnt++; $display("FAIL dual2_sel1C: got %0d want 4", alu_input1_sel_C); end
    vec_cnt++; if (alu_input2_sel_C !== 3'd2) begin err_cnt++; $display("FAIL dual2_sel2C: got %0d want 2", alu_input2_sel_C); end
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL dual2_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input2_sel !== 2'd2) begin err_cnt++; $display("FAIL dual2_sel2: got %0d want 2", alu_input2_sel); end
    $display("test_dual_result done");
  endtask

  task automatic test_load_use();
    drain();
    id_valid = 1; id_rd = 5'd9; id_we = 1; id_mem_read = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 5'd9; id_use = 6'b000001;
    #1;
    vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL lu_stall: got %0d want 1", stall); end
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL lu_bubble_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (stall_count !== 16'd1) begin err_cnt++; $display("FAIL lu_cnt: got %0d want 1", stall_count); end
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL lu_stall_drop: got %0d want 0", stall); end
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd2) begin err_cnt++; $display("FAIL lu_sel1: got %0d want 2", alu_input1_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd2) begin err_cnt++; $display("FAIL lu_sel1C: got %0d want 2", alu_input1_sel_C); end
    vec_cnt++; if (stall_count !== 16'd1) begin err_cnt++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_count); end
    $display("test_load_use done");
  endtask

  task automatic test_zero_and_flush();
    drain();
    id_valid = 1; id_rd = 5'd0; id_we = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 5'd0; id_use = 6'b000001;
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL zero_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd0) begin err_cnt++; $display("FAIL zero_sel1C: got %0d want 0", alu_input1_sel_C); end
    drain();
    id_valid = 1; id_rd = 5'd9; id_we = 1; id_mem_read = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 5'd9; id_use = 6'b000001; flush = 1;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL flush_stall: got %0d want 0", stall); end
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL flush_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd0) begin err_cnt++; $display("FAIL flush_sel1C: got %0d want 0", alu_input1_sel_C); end
    vec_cnt++; if (stall_count !== 16'd1) begin err_cnt++; $display("FAIL flush_cnt: got %0d want 1", stall_count); end
    // EX holds a bubble now; the load sits in MEM
    flush = 0;
    #1;
    vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL flush_ex_invalid: got %0d want 0", stall); end
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd2) begin err_cnt++; $display("FAIL flush_mem_sel1: got %0d want 2", alu_input1_sel); end
    $display("test_zero_and_flush done");
  endtask

  task automatic test_reset_mid();
    drain();
    id_valid = 1; id_rd = 5'd11; id_we = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 5'd11; id_use = 6'b000001; id_rd = 5'd12; id_we = 1;
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd1) begin err_cnt++; $display("FAIL rmid_pre_sel1: got %0d want 1", alu_input1_sel); end
    clear_id();
    #2;
    rst = 1;
    #1;
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL rmid_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input1_sel_C !== 3'd0) begin err_cnt++; $display("FAIL rmid_sel1C: got %0d want 0", alu_input1_sel_C); end
    vec_cnt++; if (stall_count !== 16'd0) begin err_cnt++; $display("FAIL rmid_cnt: got %0d want 0", stall_count); end
    @(negedge clk);
    rst = 0;
    id_valid = 1; id_rs = 5'd11; id_rt = 5'd12; id_use = 6'b000011;
    step();
    vec_cnt++; if (alu_input1_sel !== 2'd0) begin err_cnt++; $display("FAIL rmid_post_sel1: got %0d want 0", alu_input1_sel); end
    vec_cnt++; if (alu_input2_sel_C !== 3'd0) begin err_cnt++; $display("FAIL rmid_post_sel2C: got %0d want 0", alu_input2_sel_C); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_dual_result();
    test_load_use();
    test_zero_and_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Producer side of the EXE-stage operand-forwarding select interface.
- Tracks destination registers of in-flight instructions in its own shadow pipeline (EX and MEM slots).
- Computes and registers the per-operand select codes that the EXE stage consumes one cycle later, and raises a one-cycle load-use stall.
- Sits between decode and the ID/EX pipeline register; covers simple (2-bit select) and complex dual-result (3-bit select) instructions.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_complex  in  1  decode instruction is complex (uses 3-bit selects, may write two results).
- id_rs, id_rt, id_rs3, id_rs4, id_st, id_st2  in  REG_AW each  source indices for alu inputs 1-4, store value, store value 2.
- id_use  in  6  source-used mask; bit0=rs … bit5=st2.
- id_rd, id_rd2  in  REG_AW each  destinations for result, result2.
- id_we, id_we2  in  1 each  write enables for rd, rd2.
- id_mem_read  in  1  decode instruction is a load; its load result targets rd only.
- flush  in  1  squash decode instruction and EX slot.
- stall  out  1  hold PC/IF/ID; combinational.
- alu_input1_sel, alu_input2_sel, store_val_sel  out  2 each  simple-mode selects, registered.
- alu_input1_sel_C, alu_input2_sel_C, alu_input3_sel_C, alu_input4_sel_C, store_val_sel_C, store_val2_sel  out  3 each  complex-mode selects, registered.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding, fixed by the EXE stage:
  - 0 = register file value.
  - 1 = MEM result.
  - 2 = WB result.
  - 3 = MEM result2.
  - 4 = WB result2.
  - Simple selects use only 0/1/2.
- Shadow slots EX and MEM each hold: valid, rd, rd2, we, we2, mem_read. Reset clears all fields to 0.
- Match rules for a used, nonzero source s against slot X:
  - X.valid and X.we and s==X.rd gives an rd-hit.
  - X.valid and X.we2 and s==X.rd2 gives an rd2-hit.
  - Index 0 never matches.
- Code per source, first match wins:
  - EX rd-hit → 1.
  - EX rd2-hit → 3.
  - MEM rd-hit → 2.
  - MEM rd2-hit → 4.
  - Otherwise 0.
  - Rationale: the EX slot becomes MEM and the MEM slot becomes WB when the decode instruction enters EX.
- Simple selects: same rule restricted to rd-hits. Codes 3/4 map to 0.
  - Simple selects are driven regardless of id_complex.
  - Complex selects are driven regardless of id_complex.
  - The EXE stage chooses between them.
- Load-use stall (combinational) = id_valid & !flush & EX.valid & EX.mem_read & EX.we & (any used nonzero source == EX.rd).
- Each clock edge, unless rst:
  - MEM ← EX.
  - If flush or stall: EX ← bubble (valid=0) and all select registers ← 0.
  - Otherwise: EX ← decode fields (valid=id_valid), and select registers ← computed codes (0 if !id_valid).
- Re-evaluation after a stall: the held decode instruction is re-evaluated; the load is now in MEM, so its source gets code 2 (simple) / 2 (complex).
- stall_count increments on each cycle with stall=1 and saturates at all-ones. Reset → 0.
- Reset values: every output register 0; stall=0 while rst asserted.
- Asynchronous reset mid-operation discards both shadow slots immediately.
- Simultaneous flush and stall-condition:
  - stall output = 0.
  - Flush wins; EX gets a bubble.
- Latency: select codes are valid the cycle after decode presents the instruction, aligned with ID/EX register outputs.

Test Plan:
- Back-to-back ALU: I0 rd=5 we=1, then I1 rs=5 rt=5 simple → alu_input1_sel=alu_input2_sel=1, C selects=1, stall=0.
- Distance 2: I0 rd=7, I1 unrelated, I2 rs3=7 complex → alu_input3_sel_C=2; simple selects for rs unaffected (0).
- Complex dual result: I0 rd=3 rd2=4 we=we2=1, then I1 rs=4 rt=3 → alu_input1_sel_C=3, alu_input2_sel_C=1, alu_input1_sel=0 (simple ignores rd2). Distance 2 case → codes 4 and 2.
- Load-use: I0 load rd=9, I1 rs=9 → stall=1 for exactly one cycle, EX bubble, stall_count=1; next cycle I1 issues with alu_input1_sel=2.
- Zero register and flush: I0 rd=0 we=1, I1 rs=0 → sel 0. Load rd=9 followed by flush with I1 rs=9 → stall=0, selects 0, EX slot invalid.
- Reset mid-pipeline: assert rst with EX/MEM valid → all outputs 0 asynchronously. After release, I rs=prior rd → sel 0.
